// File: rtl/mlp_hls_dbg_pkg.sv
// Shared debug-controller types: FSM state encoding, report record and
// glitch counter helpers for the MLP HLS deadlock supervisory logic.
package mlp_hls_dbg_pkg;

    localparam int unsigned GLITCH_W      = 8;
    localparam int unsigned RPT_IDX_MAX_W = 8;
    localparam int unsigned RPT_TS_MAX_W  = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CONFIRM = 3'd2,
        ST_REPORT  = 3'd3,
        ST_HALT    = 3'd4
    } dbg_state_e;

    // Widest record any configuration may emit; instances use the low bits.
    typedef struct packed {
        logic [RPT_IDX_MAX_W-1:0] idx;
        logic [RPT_TS_MAX_W-1:0]  ts;
    } rpt_rec_t;

    function automatic logic [GLITCH_W-1:0] glitch_sat_inc(input logic [GLITCH_W-1:0] cnt);
        logic [GLITCH_W-1:0] res;
        if (cnt == 8'hFF) begin
            res = cnt;
        end else begin
            res = cnt + 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mlp_hls_lowest_set_idx.sv
// Combinational priority encoder: index of the lowest set bit plus a found flag.
module mlp_hls_lowest_set_idx #(
    parameter int unsigned N_MON = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N_MON-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N_MON - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end else begin
                found_o = found_o;
            end
        end
    end

endmodule

// File: rtl/mlp_hls_deadlock_report_ctrl.sv
// Supervisory deadlock controller: confirms a persistent monitor block flag,
// reports it once with a timestamp and holds a sticky status until cleared.
module mlp_hls_deadlock_report_ctrl
    import mlp_hls_dbg_pkg::*;
#(
    parameter int unsigned N_MON          = 4,
    parameter int unsigned IDX_W          = 2,
    parameter int unsigned CONFIRM_CYCLES = 16,
    parameter int unsigned TS_W           = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                clear,
    input  logic [N_MON-1:0]    mon_block,
    output logic                rpt_valid,
    input  logic                rpt_ready,
    output logic [IDX_W-1:0]    rpt_idx,
    output logic [TS_W-1:0]     rpt_ts,
    output logic                deadlock,
    output logic [GLITCH_W-1:0] glitch_cnt,
    output logic                busy
);

    localparam int unsigned     CONF_W    = $clog2(CONFIRM_CYCLES);
    localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_CYCLES - 1);

    dbg_state_e          state_q, state_d;
    logic [TS_W-1:0]     ts_cnt_q;
    logic [CONF_W-1:0]   conf_cnt_q, conf_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TS_W-1:0]     ts_q, ts_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic                deadlock_q, deadlock_d;
    logic                rpt_valid_q, busy_q;
    logic [IDX_W-1:0]    low_idx_s;
    logic                low_found_s;
    logic                hit_s;

    mlp_hls_lowest_set_idx #(
        .N_MON (N_MON),
        .IDX_W (IDX_W)
    ) u_lowest_set_idx (
        .vec_i   (mon_block),
        .idx_o   (low_idx_s),
        .found_o (low_found_s)
    );

    // Only the captured monitor matters once confirmation has started.
    assign hit_s = mon_block[idx_q];

    // Free-running timestamp; clear deliberately leaves it alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            ts_cnt_q <= '0;
        end else begin
            ts_cnt_q <= ts_cnt_q + TS_W'(1);
        end
    end

    // Next-state and datapath updates; clear overrides every transition.
    always_comb begin
        state_d    = state_q;
        conf_cnt_d = conf_cnt_q;
        idx_d      = idx_q;
        ts_d       = ts_q;
        glitch_d   = glitch_q;
        deadlock_d = deadlock_q;
        if (clear) begin
            state_d    = ST_IDLE;
            conf_cnt_d = '0;
            glitch_d   = '0;
            deadlock_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (low_found_s) begin
                        state_d    = ST_CONFIRM;
                        idx_d      = low_idx_s;
                        ts_d       = ts_cnt_q;
                        conf_cnt_d = CONF_W'(1);
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_CONFIRM: begin
                    if (!enable) begin
                        state_d    = ST_IDLE;
                        conf_cnt_d = '0;
                    end else if (!hit_s) begin
                        state_d    = ST_ARMED;
                        conf_cnt_d = '0;
                        glitch_d   = glitch_sat_inc(glitch_q);
                    end else if (conf_cnt_q == CONF_LAST) begin
                        state_d = ST_REPORT;
                    end else begin
                        conf_cnt_d = conf_cnt_q + CONF_W'(1);
                    end
                end
                ST_REPORT: begin
                    if (rpt_ready) begin
                        state_d    = ST_HALT;
                        deadlock_d = 1'b1;
                    end else begin
                        state_d = ST_REPORT;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; status flags follow the next state so they align with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            conf_cnt_q  <= '0;
            idx_q       <= '0;
            ts_q        <= '0;
            glitch_q    <= '0;
            deadlock_q  <= 1'b0;
            rpt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            conf_cnt_q  <= conf_cnt_d;
            idx_q       <= idx_d;
            ts_q        <= ts_d;
            glitch_q    <= glitch_d;
            deadlock_q  <= deadlock_d;
            rpt_valid_q <= (state_d == ST_REPORT);
            busy_q      <= (state_d == ST_CONFIRM) || (state_d == ST_REPORT);
        end
    end

    assign rpt_valid  = rpt_valid_q;
    assign rpt_idx    = idx_q;
    assign rpt_ts     = ts_q;
    assign deadlock   = deadlock_q;
    assign glitch_cnt = glitch_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mlp_hls_deadlock_report_ctrl.sv
// Self-checking bench for mlp_hls_deadlock_report_ctrl: vector table, directed
// corner sequences and randomized traffic against a run-length reference model.
module tb_mlp_hls_deadlock_report_ctrl;

    localparam int N_MON  = 4;
    localparam int CONF   = 16;
    localparam int TS_W_S = 5;

    localparam int M_IDLE    = 0;
    localparam int M_ARMED   = 1;
    localparam int M_CONFIRM = 2;
    localparam int M_REPORT  = 3;
    localparam int M_HALT    = 4;

    logic        clock = 1'b0;
    logic        reset, enable, clear, rpt_ready;
    logic [3:0]  mon_block;
    logic        rpt_valid, deadlock, busy;
    logic [1:0]  rpt_idx;
    logic [31:0] rpt_ts;
    logic [7:0]  glitch_cnt;
    logic        s_rpt_valid, s_deadlock, s_busy;
    logic [1:0]  s_rpt_idx;
    logic [TS_W_S-1:0] s_rpt_ts;
    logic [7:0]  s_glitch_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int          m_mode, m_idx, m_run, m_glitch;
    bit          m_dead;
    logic [31:0] m_ts, m_cnt;

    always #5 clock = ~clock;

    mlp_hls_deadlock_report_ctrl #(
        .N_MON(4), .IDX_W(2), .CONFIRM_CYCLES(CONF), .TS_W(32)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .mon_block(mon_block), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_idx(rpt_idx), .rpt_ts(rpt_ts), .deadlock(deadlock),
        .glitch_cnt(glitch_cnt), .busy(busy)
    );

    // Narrow-timestamp instance on the same stimulus, used to observe wraparound.
    mlp_hls_deadlock_report_ctrl #(
        .N_MON(4), .IDX_W(2), .CONFIRM_CYCLES(CONF), .TS_W(TS_W_S)
    ) dut_s (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .mon_block(mon_block), .rpt_valid(s_rpt_valid), .rpt_ready(rpt_ready),
        .rpt_idx(s_rpt_idx), .rpt_ts(s_rpt_ts), .deadlock(s_deadlock),
        .glitch_cnt(s_glitch_cnt), .busy(s_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [31:0] cap;
        if (reset) begin
            m_mode = M_IDLE; m_idx = 0; m_run = 0; m_glitch = 0;
            m_dead = 1'b0; m_ts = '0; m_cnt = '0;
            return;
        end
        cap   = m_cnt;
        m_cnt = m_cnt + 32'd1;
        if (clear) begin
            m_mode = M_IDLE; m_run = 0; m_glitch = 0; m_dead = 1'b0;
            return;
        end
        case (m_mode)
            M_IDLE:  if (enable) m_mode = M_ARMED;
            M_ARMED: begin
                if (!enable) m_mode = M_IDLE;
                else if (mon_block != 4'd0) begin
                    for (int i = 0; i < N_MON; i++)
                        if (mon_block[i]) begin m_idx = i; break; end
                    m_ts = cap; m_run = 1; m_mode = M_CONFIRM;
                end
            end
            M_CONFIRM: begin
                if (!enable) m_mode = M_IDLE;
                else if (!mon_block[m_idx]) begin
                    m_glitch = (m_glitch < 255) ? m_glitch + 1 : 255;
                    m_mode = M_ARMED;
                end else begin
                    m_run++;
                    if (m_run == CONF) m_mode = M_REPORT;
                end
            end
            M_REPORT: if (rpt_ready) begin m_mode = M_HALT; m_dead = 1'b1; end
            default: ;
        endcase
    endtask

    // One clock: advance the model with the applied inputs, then compare after the edge.
    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        chk("rpt_valid", 64'(rpt_valid), 64'(m_mode == M_REPORT));
        chk("busy", 64'(busy), 64'((m_mode == M_CONFIRM) || (m_mode == M_REPORT)));
        chk("deadlock", 64'(deadlock), 64'(m_dead));
        chk("glitch_cnt", 64'(glitch_cnt), 64'(m_glitch));
        chk("s_rpt_valid", 64'(s_rpt_valid), 64'(m_mode == M_REPORT));
        chk("s_busy", 64'(s_busy), 64'((m_mode == M_CONFIRM) || (m_mode == M_REPORT)));
        chk("s_deadlock", 64'(s_deadlock), 64'(m_dead));
        chk("s_glitch_cnt", 64'(s_glitch_cnt), 64'(m_glitch));
        if (m_mode == M_REPORT) begin
            chk("rpt_idx", 64'(rpt_idx), 64'(m_idx));
            chk("rpt_ts", 64'(rpt_ts), 64'(m_ts));
            chk("s_rpt_idx", 64'(s_rpt_idx), 64'(m_idx));
            chk("s_rpt_ts", 64'(s_rpt_ts), 64'(m_ts[TS_W_S-1:0]));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; clear = 1'b0; mon_block = 4'd0; rpt_ready = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    typedef struct {
        logic       en, clr, rdy;
        logic [3:0] blk;
        int         reps;
        logic       ev, eb, ed;
        int         eg;
        int         eidx;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 4'b0000,  1, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 4'b0100, 16, 1'b1, 1'b1, 1'b0, 0, 2};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 4'b0000, 20, 1'b1, 1'b1, 1'b0, 0, 2};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 4'b0000,  1, 1'b0, 1'b0, 1'b1, 0, 0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 4'b0000,  1, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 4'b0000,  1, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 4'b0001, 15, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 4'b0000,  1, 1'b0, 1'b0, 1'b0, 1, 0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 4'b0000,  1, 1'b0, 1'b0, 1'b0, 1, 0};

        // reset state
        do_reset();
        chk("rst_valid", 64'(rpt_valid), 64'd0);
        chk("rst_idx", 64'(rpt_idx), 64'd0);
        chk("rst_ts", 64'(rpt_ts), 64'd0);
        chk("rst_deadlock", 64'(deadlock), 64'd0);
        chk("rst_glitch", 64'(glitch_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // vector table
        for (int v = 0; v < 9; v++) begin
            enable = tbl[v].en; clear = tbl[v].clr; rpt_ready = tbl[v].rdy; mon_block = tbl[v].blk;
            repeat (tbl[v].reps) cycle();
            chk("tbl_valid", 64'(rpt_valid), 64'(tbl[v].ev));
            chk("tbl_busy", 64'(busy), 64'(tbl[v].eb));
            chk("tbl_deadlock", 64'(deadlock), 64'(tbl[v].ed));
            chk("tbl_glitch", 64'(glitch_cnt), 64'(tbl[v].eg));
            if (tbl[v].ev) chk("tbl_idx", 64'(rpt_idx), 64'(tbl[v].eidx));
        end
        clear = 1'b0;

        // detection at edge 10 reports ts 10, handshake one cycle later
        do_reset();
        enable = 1'b1; rpt_ready = 1'b1;
        cycle();
        repeat (9) cycle();
        mon_block = 4'b0100;
        repeat (16) cycle();
        chk("lat_valid", 64'(rpt_valid), 64'd1);
        chk("lat_idx", 64'(rpt_idx), 64'd2);
        chk("lat_ts", 64'(rpt_ts), 64'd10);
        cycle();
        chk("lat_valid_drop", 64'(rpt_valid), 64'd0);
        chk("lat_deadlock", 64'(deadlock), 64'd1);

        // arbitration, glitch on the winner, re-detect on the survivor
        do_reset();
        enable = 1'b1;
        cycle();
        mon_block = 4'b1010;
        repeat (5) cycle();
        chk("arb_busy", 64'(busy), 64'd1);
        mon_block = 4'b1000;
        cycle();
        chk("arb_glitch", 64'(glitch_cnt), 64'd1);
        chk("arb_armed", 64'(busy), 64'd0);
        repeat (16) cycle();
        chk("arb_idx", 64'(rpt_idx), 64'd3);
        chk("arb_ts", 64'(rpt_ts), 64'd7);

        // back-pressure: record held while inputs wiggle
        enable = 1'b0; mon_block = 4'b0000;
        for (int k = 0; k < 20; k++) begin
            mon_block = 4'($urandom);
            cycle();
            chk("hold_valid", 64'(rpt_valid), 64'd1);
            chk("hold_idx", 64'(rpt_idx), 64'd3);
            chk("hold_ts", 64'(rpt_ts), 64'd7);
        end
        rpt_ready = 1'b1;
        cycle();
        chk("hs_deadlock", 64'(deadlock), 64'd1);
        rpt_ready = 1'b0; clear = 1'b1;
        cycle();
        clear = 1'b0;
        chk("clr_deadlock", 64'(deadlock), 64'd0);
        chk("clr_glitch", 64'(glitch_cnt), 64'd0);
        enable = 1'b1; mon_block = 4'b1111;
        cycle();
        chk("clr_idle", 64'(busy), 64'd0);

        // clear racing the handshake wins
        repeat (16) cycle();
        chk("race_valid_pre", 64'(rpt_valid), 64'd1);
        clear = 1'b1; rpt_ready = 1'b1;
        cycle();
        clear = 1'b0; rpt_ready = 1'b0;
        chk("race_valid", 64'(rpt_valid), 64'd0);
        chk("race_deadlock", 64'(deadlock), 64'd0);

        // enable drop in CONFIRM is not a glitch
        mon_block = 4'b0000;
        cycle();
        mon_block = 4'b0100;
        repeat (5) cycle();
        enable = 1'b0;
        cycle();
        chk("en_drop_busy", 64'(busy), 64'd0);
        chk("en_drop_glitch", 64'(glitch_cnt), 64'd0);

        // reset in the middle of a report
        enable = 1'b1; mon_block = 4'b0000;
        cycle();
        mon_block = 4'b0010;
        repeat (16) cycle();
        chk("mid_rst_pre", 64'(rpt_valid), 64'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mid_rst_valid", 64'(rpt_valid), 64'd0);
        chk("mid_rst_idx", 64'(rpt_idx), 64'd0);
        chk("mid_rst_ts", 64'(rpt_ts), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);

        // glitch counter saturation
        do_reset();
        enable = 1'b1;
        cycle();
        for (int g = 0; g < 300; g++) begin
            mon_block = 4'b0001;
            repeat (15) cycle();
            mon_block = 4'b0000;
            cycle();
        end
        chk("glitch_sat", 64'(glitch_cnt), 64'd255);

        // detection exactly where the narrow timestamp wraps to zero
        do_reset();
        enable = 1'b1;
        cycle();
        for (int w = 0; w < 40 && m_cnt[TS_W_S-1:0] != 5'd0; w++) cycle();
        mon_block = 4'b0010;
        repeat (16) cycle();
        chk("wrap_valid", 64'(s_rpt_valid), 64'd1);
        chk("wrap_s_ts", 64'(s_rpt_ts), 64'd0);
        chk("wrap_ts", 64'(rpt_ts), 64'd32);

        // randomized traffic against the model
        do_reset();
        for (int r = 0; r < 3000; r++) begin
            reset     = ($urandom_range(0, 599) == 0);
            enable    = ($urandom_range(0, 15) != 0);
            clear     = ($urandom_range(0, 149) == 0);
            rpt_ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 29) == 0)
                mon_block = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
